triangle_sequencer: RTL

Frame-level control stage between the register target and the per-triangle pipeline (data_fetch -> vertex_computation -> pixel_computation). It accepts a frame launch and walks the triangle and colour arrays. It keeps up to three triangles in flight, one per stage, and issues start pulses. It collects each stage's eoc and produces a pipeline-advance strobe, frame-done and irq.

---
 rtl/triangle_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/triangle_sequencer.sv
// rtl/triangle_sequencer.sv - frame sequencer keeping three triangles in flight across fetch/vertex/pixel stages
// Optional watchdog on each WAIT phase: define TRI_SEQ_TIMEOUT_EN.
module triangle_sequencer #(
    parameter int MADDR_WIDTH    = 32,
    parameter int VERTEX_STRIDE  = 18,
    parameter int COLOR_STRIDE   = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_start,
    input  logic [31:0]            triangles_count,
    input  logic [MADDR_WIDTH-1:0] base_addr_vertex,
    input  logic [MADDR_WIDTH-1:0] base_addr_color,
    input  logic                   irq_ack,
    input  logic                   fetch_eoc,
    input  logic                   ver_eoc,
    input  logic                   pix_eoc,
    output logic                   fetch_start,
    output logic                   ver_start,
    output logic                   pix_start,
    output logic [MADDR_WIDTH-1:0] fetch_addr_vertex,
    output logic [MADDR_WIDTH-1:0] fetch_addr_color,
    output logic                   advance,
    output logic                   busy,
    output logic                   frame_done,
    output logic [31:0]            triangles_done,
    output logic                   irq,
    output logic                   error
);

    typedef enum logic [1:0] {IDLE, ADVANCE, START, WAIT} state_t;

    state_t                 state;
    logic [31:0]            count;
    logic [31:0]            issued;
    logic [MADDR_WIDTH-1:0] next_vertex;
    logic [MADDR_WIDTH-1:0] next_color;
    logic                   v_f, v_v, v_p;
    logic                   d_f, d_v, d_p;
    logic                   new_v_f;
    logic                   stages_done;
    logic                   timeout_hit;

    assign new_v_f     = (issued < count);
    // Eocs landing in the current WAIT cycle count, so the advance is not delayed by a cycle.
    assign stages_done = (d_f | fetch_eoc | !v_f) &
                         (d_v | ver_eoc   | !v_v) &
                         (d_p | pix_eoc   | !v_p);

`ifdef TRI_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    assign timeout_hit = (state == WAIT) && !stages_done &&
                         (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
            error  <= 1'b0;
        end else begin
            if (state == WAIT)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;
            if (state == IDLE && frame_start)
                error <= 1'b0;
            else if (timeout_hit)
                error <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            count             <= '0;
            issued            <= '0;
            next_vertex       <= '0;
            next_color        <= '0;
            v_f               <= 1'b0;
            v_v               <= 1'b0;
            v_p               <= 1'b0;
            d_f               <= 1'b0;
            d_v               <= 1'b0;
            d_p               <= 1'b0;
            fetch_start       <= 1'b0;
            ver_start         <= 1'b0;
            pix_start         <= 1'b0;
            fetch_addr_vertex <= '0;
            fetch_addr_color  <= '0;
            advance           <= 1'b0;
            busy              <= 1'b0;
            frame_done        <= 1'b0;
            triangles_done    <= '0;
            irq               <= 1'b0;
        end else begin
            fetch_start <= 1'b0;
            ver_start   <= 1'b0;
            pix_start   <= 1'b0;
            advance     <= 1'b0;
            frame_done  <= 1'b0;
            // Later set assignments override this, so a same-cycle set wins over ack.
            if (irq_ack)
                irq <= 1'b0;

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        count          <= triangles_count;
                        next_vertex    <= base_addr_vertex;
                        next_color     <= base_addr_color;
                        issued         <= '0;
                        triangles_done <= '0;
                        if (triangles_count == 32'd0) begin
                            frame_done <= 1'b1;
                            irq        <= 1'b1;
                        end else begin
                            busy    <= 1'b1;
                            advance <= 1'b1;
                            state   <= ADVANCE;
                        end
                    end
                end

                ADVANCE: begin
                    v_p <= v_v;
                    v_v <= v_f;
                    v_f <= new_v_f;
                    if (v_p)
                        triangles_done <= triangles_done + 32'd1;
                    if (new_v_f) begin
                        fetch_addr_vertex <= next_vertex;
                        fetch_addr_color  <= next_color;
                        next_vertex       <= next_vertex + MADDR_WIDTH'(VERTEX_STRIDE);
                        next_color        <= next_color + MADDR_WIDTH'(COLOR_STRIDE);
                        issued            <= issued + 32'd1;
                    end
                    if (!new_v_f && !v_f && !v_v) begin
                        frame_done <= 1'b1;
                        irq        <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        fetch_start <= new_v_f;
                        ver_start   <= v_f;
                        pix_start   <= v_v;
                        state       <= START;
                    end
                end

                START: begin
                    d_f   <= 1'b0;
                    d_v   <= 1'b0;
                    d_p   <= 1'b0;
                    state <= WAIT;
                end

                WAIT: begin
                    if (timeout_hit) begin
                        v_f   <= 1'b0;
                        v_v   <= 1'b0;
                        v_p   <= 1'b0;
                        irq   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (stages_done) begin
                        advance <= 1'b1;
                        state   <= ADVANCE;
                    end else begin
                        d_f <= d_f | (fetch_eoc & v_f);
                        d_v <= d_v | (ver_eoc & v_v);
                        d_p <= d_p | (pix_eoc & v_p);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
